pc_updater: RTL and testbench

PC_UPDATER -- requirements
Module: pc_updater

---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/pc_next_logic.sv | 64 ++++++
 rtl/pc_updater.sv | 62 ++++++
 tb/tb_pc_updater.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
// Shared RV32I control definitions: the instruction type codes carried in
// cword[3:0] and the bit positions of the control word fields used by the PC
// logic (type, branch_taken, stall).
// -----------------------------------------------------------------------------
package rv32i_pkg;

  // Width of the full control word; only the low fields are used here.
  localparam int CWORD_W       = 23;

  // Control word field positions.
  localparam int CW_TYPE_LSB   = 0;
  localparam int CW_TYPE_MSB   = 3;
  localparam int CW_BRANCH_BIT = 4;
  localparam int CW_STALL_BIT  = 5;

  // Increment used for every sequential (non-redirecting) instruction.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction type codes. Codes 9-15 are undefined and behave as
  // sequential instructions.
  typedef enum logic [3:0] {
    INSTR_LOAD   = 4'd0,
    INSTR_OPIMM  = 4'd1,
    INSTR_STORE  = 4'd2,
    INSTR_OPREG  = 4'd3,
    INSTR_LUI    = 4'd4,
    INSTR_AUIPC  = 4'd5,
    INSTR_BRANCH = 4'd6,
    INSTR_JALR   = 4'd7,
    INSTR_JAL    = 4'd8
  } instr_type_e;

endpackage : rv32i_pkg

// File: rtl/pc_next_logic.sv
// -----------------------------------------------------------------------------
// pc_next_logic
// Purely combinational next-PC selection.
//   pc           in  : current program counter
//   itype        in  : instruction type code
//   branch_taken in  : branch resolution, only meaningful for branches
//   imm          in  : sign-extended immediate
//   r            in  : rs1 value, only used by jalr
//   next_pc      out : PC to load on the next unstalled edge
// All sums are 32-bit and wrap modulo 2^32. No alignment check is made on
// pc + imm targets; only the jalr target has bit 0 cleared.
// -----------------------------------------------------------------------------
module pc_next_logic
  import rv32i_pkg::*;
(
  input  logic [31:0] pc,
  input  instr_type_e itype,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] r,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4_s;
  logic [31:0] pc_plus_imm_s;
  logic [31:0] jalr_sum_s;

  assign pc_plus4_s    = pc + PC_STEP;
  assign pc_plus_imm_s = pc + imm;
  assign jalr_sum_s    = r + imm;

  // Select the next PC from the instruction type; branch_taken only matters for branches.
  always_comb begin
    next_pc = pc_plus4_s;
    case (itype)
      INSTR_LOAD,
      INSTR_OPIMM,
      INSTR_STORE,
      INSTR_OPREG,
      INSTR_LUI,
      INSTR_AUIPC: begin
        next_pc = pc_plus4_s;
      end
      INSTR_BRANCH: begin
        if (branch_taken) begin
          next_pc = pc_plus_imm_s;
        end else begin
          next_pc = pc_plus4_s;
        end
      end
      INSTR_JALR: begin
        next_pc = {jalr_sum_s[31:1], 1'b0};
      end
      INSTR_JAL: begin
        next_pc = pc_plus_imm_s;
      end
      default: begin
        // Undefined codes fall through as sequential instructions.
        next_pc = pc_plus4_s;
      end
    endcase
  end

endmodule : pc_next_logic

// File: rtl/pc_updater.sv
// -----------------------------------------------------------------------------
// pc_updater
// Program counter register with one-edge update latency.
//   clk    in  : clock, all updates on the rising edge
//   cword  in  : control word; [3:0] type, [4] branch_taken, [5] stall,
//                [22:6] unused here
//   imm    in  : sign-extended immediate
//   r      in  : rs1 value for jalr
//   pc     out : current program counter, straight from the register
//   rst_n  in  : synchronous active-low reset, loads RESET_PC
// Reset has priority over stall, and stall has priority over every type.
// -----------------------------------------------------------------------------
module pc_updater
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic [CWORD_W-1:0] cword,
  input  logic [31:0]        imm,
  input  logic [31:0]        r,
  output logic [31:0]        pc,
  input  logic               rst_n
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  instr_type_e itype_s;
  logic        branch_taken_s;
  logic        stall_s;
  logic        unused_cword_s;

  assign itype_s        = instr_type_e'(cword[CW_TYPE_MSB:CW_TYPE_LSB]);
  assign branch_taken_s = cword[CW_BRANCH_BIT];
  assign stall_s        = cword[CW_STALL_BIT];

  // The upper control word bits belong to other pipeline blocks.
  assign unused_cword_s = ^cword[CWORD_W-1:CW_STALL_BIT+1];

  pc_next_logic u_pc_next_logic (
    .pc           (pc_r),
    .itype        (itype_s),
    .branch_taken (branch_taken_s),
    .imm          (imm),
    .r            (r),
    .next_pc      (next_pc_s)
  );

  // PC register: synchronous reset first, then stall hold, then normal update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (stall_s) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign pc = pc_r;

endmodule : pc_updater

// File: tb/tb_pc_updater.sv
// -----------------------------------------------------------------------------
// tb_pc_updater
// Directed and randomized self-checking bench for pc_updater. Expected PC
// values come from a behavioural model of the next-PC rules kept here.
// -----------------------------------------------------------------------------
module tb_pc_updater;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic [22:0] cword;
  logic [31:0] imm;
  logic [31:0] r;
  logic [31:0] pc;
  logic        rst_n;

  int checks;
  int failures;
  logic [31:0] model_pc;

  pc_updater #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .cword (cword),
    .imm   (imm),
    .r     (r),
    .pc    (pc),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural next-PC rule set.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [22:0] cw,
                                           input logic [31:0] im, input logic [31:0] rv);
    int unsigned t;
    t = cw[3:0];
    if (t == 6 && cw[4]) return p + im;
    if (t == 8) return p + im;
    if (t == 7) return (rv + im) & 32'hFFFF_FFFE;
    return p + 32'd4;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] t, input logic br, input logic st,
                        input logic [31:0] im, input logic [31:0] rv);
    cword = {17'd0, st, br, t};
    imm   = im;
    r     = rv;
  endtask

  // One clock edge: predict, advance, then compare against the model.
  task automatic tick(input string tag);
    logic [31:0] e;
    if (!rst_n)        e = RESET_PC;
    else if (cword[5]) e = model_pc;
    else               e = ref_next(model_pc, cword, imm, r);
    @(posedge clk);
    #1;
    model_pc = e;
    check(tag, pc, e);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_pc = 32'h0;
    rst_n    = 1'b0;
    set_in(4'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Reset state
    tick("reset0");
    tick("reset1");
    check("reset_pc", pc, RESET_PC);

    // Sequential counting from reset
    rst_n = 1'b1;
    for (int i = 1; i < 7; i++) begin
      tick("seq");
      check("seq_const", pc, 32'(4 * i));
    end

    // Branch taken from pc=8
    rst_n = 1'b0; tick("rst_b1");
    rst_n = 1'b1; tick("b1_a"); tick("b1_b");
    check("pc8", pc, 32'd8);
    set_in(4'd6, 1'b1, 1'b0, 32'd15, 32'd0);
    tick("br_taken");
    check("br_taken_const", pc, 32'd23);

    // Branch not taken from pc=8
    rst_n = 1'b0; set_in(4'd0, 1'b0, 1'b0, 32'd0, 32'd0); tick("rst_b2");
    rst_n = 1'b1; tick("b2_a"); tick("b2_b");
    set_in(4'd6, 1'b0, 1'b0, 32'd15, 32'd0);
    tick("br_not");
    check("br_not_const", pc, 32'd12);

    // jalr with bit 0 cleared
    set_in(4'd7, 1'b0, 1'b0, 32'd15, 32'd9);
    tick("jalr9");
    check("jalr9_const", pc, 32'd24);
    set_in(4'd7, 1'b1, 1'b0, 32'd15, 32'd10);
    tick("jalr10");
    check("jalr10_const", pc, 32'd24);

    // jal with negative offset, then wrap-around
    set_in(4'd7, 1'b0, 1'b0, 32'd0, 32'h0000_0100);
    tick("to_100");
    set_in(4'd8, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
    tick("jal_neg");
    check("jal_neg_const", pc, 32'h0000_00F0);
    set_in(4'd7, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC);
    tick("to_fffc");
    set_in(4'd0, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
    tick("wrap");
    check("wrap_const", pc, 32'h0);

    // Stall holds for three edges, then resumes
    set_in(4'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick("pre_stall");
    set_in(4'd1, 1'b0, 1'b1, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick("stall");
      check("stall_const", pc, 32'd4);
    end
    set_in(4'd1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick("unstall");
    check("unstall_const", pc, 32'd8);

    // Reset mid-run overrides stall and jal; asserted mid-cycle only acts on an edge
    set_in(4'd8, 1'b0, 1'b1, 32'h0000_0040, 32'd0);
    rst_n = 1'b0;
    #2;
    check("rst_no_async", pc, 32'd8);
    tick("rst_mid");
    check("rst_mid_const", pc, RESET_PC);
    rst_n = 1'b1;
    set_in(4'd11, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0080);
    #2;
    check("rel_no_async", pc, RESET_PC);
    tick("undef11");
    check("undef11_const", pc, RESET_PC + 32'd4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cword = 23'($urandom);
      if ($urandom_range(0, 3) == 0) cword[5] = 1'b0;
      imm   = $urandom;
      r     = $urandom;
      rst_n = ($urandom_range(0, 19) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pc_updater
